// File: rtl/gmii_tx_pkg.sv
// gmii_tx_pkg: shared constants, state encoding and sizing helper for the GMII TX scheduler
package gmii_tx_pkg;
  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE = 8'hD5;
  localparam int PRE_LEN_DEF = 7;
  localparam int IFG_LEN_DEF = 11;
  localparam int MAX_LEN_DEF = 1518;
  typedef enum logic [2:0] {IDLE, PRE, SFD, DATA, IFG} state_t;
  typedef enum logic [1:0] {END_LAST, END_OVER, END_UNDER} end_t;
  function automatic int cnt_width(int a, int b, int c);
    int m;
    m = a > b ? a : b;
    m = m > c ? m : c;
    return $clog2(m + 1);
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching upward from the slot after ptr
module rr_arbiter #(
  parameter int N_REQ = 2,
  localparam int IW = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [IW-1:0]    grant,
  output logic             grant_valid
);
  logic [IW-1:0] idx;
  // walk candidates from farthest to nearest so the nearest requester after ptr wins
  always_comb begin
    grant = '0;
    idx = '0;
    grant_valid = |req;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = IW'((int'(ptr) + k) % N_REQ);
      if (req[idx]) grant = idx;
    end
  end
endmodule

// File: rtl/gmii_tx_sched.sv
// gmii_tx_sched: round-robin frame scheduler adding preamble/SFD, enforcing IFG, aborting on underrun/oversize
module gmii_tx_sched
  import gmii_tx_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int PRE_LEN = PRE_LEN_DEF,
  parameter int IFG_LEN = IFG_LEN_DEF,
  parameter int MAX_LEN = MAX_LEN_DEF,
  localparam int IW = $clog2(N_REQ)
) (
  input  logic               gmii_tx_clk,
  input  logic               rst,
  input  logic               tx_enable,
  input  logic [N_REQ-1:0]   s_valid,
  input  logic [8*N_REQ-1:0] s_data,
  input  logic [N_REQ-1:0]   s_last,
  output logic [N_REQ-1:0]   s_ready,
  output logic               gmii_tx_en,
  output logic [7:0]         gmii_txd,
  output logic               busy,
  output logic [IW-1:0]      grant_id,
  output logic               frame_done,
  output logic               underrun,
  output logic               oversize
);
  localparam int CW = cnt_width(MAX_LEN, PRE_LEN, IFG_LEN);
  state_t state, state_n;
  end_t kind, kind_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [IW-1:0] ptr, ptr_n, gid_n, pick;
  logic pick_valid, en_n, fd_n, ur_n, ov_n, v, l;
  logic [7:0] txd_n, d;
  assign v = s_valid[grant_id];
  assign l = s_last[grant_id];
  assign d = s_data[{grant_id, 3'b000} +: 8];
  assign busy = state != IDLE;
  assign s_ready = (state == DATA) ? N_REQ'(1) << grant_id : '0;
  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req(s_valid),
    .ptr(ptr),
    .grant(pick),
    .grant_valid(pick_valid)
  );
  // state, counters and registered GMII outputs; the pointer starts at N_REQ-1 so requester 0 wins first
  always_ff @(posedge gmii_tx_clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      ptr <= IW'(N_REQ - 1);
      grant_id <= '0;
      kind <= END_LAST;
      gmii_tx_en <= 1'b0;
      gmii_txd <= 8'h00;
      frame_done <= 1'b0;
      underrun <= 1'b0;
      oversize <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      ptr <= ptr_n;
      grant_id <= gid_n;
      kind <= kind_n;
      gmii_tx_en <= en_n;
      gmii_txd <= txd_n;
      frame_done <= fd_n;
      underrun <= ur_n;
      oversize <= ov_n;
    end
  end
  // next state and next outputs; a normal or oversize end is reported on the first IFG cycle when en drops
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    ptr_n = ptr;
    gid_n = grant_id;
    kind_n = kind;
    en_n = 1'b0;
    txd_n = 8'h00;
    fd_n = 1'b0;
    ur_n = 1'b0;
    ov_n = 1'b0;
    case (state)
      IDLE: if (tx_enable && pick_valid) begin
        state_n = PRE;
        gid_n = pick;
        ptr_n = pick;
        cnt_n = '0;
      end
      PRE: begin
        en_n = 1'b1;
        txd_n = PREAMBLE_BYTE;
        cnt_n = cnt + CW'(1);
        if (cnt == CW'(PRE_LEN - 1)) state_n = SFD;
      end
      SFD: begin
        en_n = 1'b1;
        txd_n = SFD_BYTE;
        cnt_n = '0;
        state_n = DATA;
      end
      DATA: if (v) begin
        en_n = 1'b1;
        txd_n = d;
        cnt_n = cnt + CW'(1);
        if (l || cnt_n == CW'(MAX_LEN)) begin
          state_n = IFG;
          kind_n = l ? END_LAST : END_OVER;
          cnt_n = '0;
        end
      end else begin
        ur_n = 1'b1;
        state_n = IFG;
        kind_n = END_UNDER;
        cnt_n = '0;
      end
      IFG: begin
        fd_n = cnt == '0 && kind == END_LAST;
        ov_n = cnt == '0 && kind == END_OVER;
        cnt_n = cnt + CW'(1);
        if (cnt == CW'(IFG_LEN - 1)) begin
          state_n = IDLE;
          cnt_n = '0;
        end
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_gmii_tx_sched.sv
// tb_gmii_tx_sched: randomized frame sources against a frame-level scheduling model
module tb_gmii_tx_sched;
  localparam int N = 2;
  localparam int PRE = 7;
  localparam int IFG = 11;
  localparam int MAXL = 80;
  logic clk = 1'b0;
  logic rst;
  logic tx_enable = 1'b0;
  logic [1:0] s_valid, s_last, s_ready;
  logic [15:0] s_data;
  logic en, busy, frame_done, underrun, oversize;
  logic [7:0] txd;
  logic [0:0] grant_id;
  gmii_tx_sched #(.N_REQ(N), .PRE_LEN(PRE), .IFG_LEN(IFG), .MAX_LEN(MAXL)) dut (
    .gmii_tx_clk(clk),
    .rst(rst),
    .tx_enable(tx_enable),
    .s_valid(s_valid),
    .s_data(s_data),
    .s_last(s_last),
    .s_ready(s_ready),
    .gmii_tx_en(en),
    .gmii_txd(txd),
    .busy(busy),
    .grant_id(grant_id),
    .frame_done(frame_done),
    .underrun(underrun),
    .oversize(oversize)
  );
  always #5 clk = ~clk;
  int ncmp = 0;
  int nfail = 0;
  logic [7:0] mem [2][0:4095];
  int flen [2][0:127];
  int fcut [2][0:127];
  int fbase [2][0:127];
  int fh [2];
  int ft [2];
  int wp [2];
  int idx [2];
  bit cutw [2];
  logic [1:0] hs;
  int mptr;
  bit in_burst, have_prev, b2b;
  int pos, exp_len, gap;
  logic [7:0] expb [0:255];
  logic [2:0] exp_kind, prev_kind;
  logic busy_d1, busy_d2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    ncmp++;
    assert (obs === expv) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic bit pending(input int r);
    return fh[r] != ft[r];
  endfunction

  task automatic add_frame(input int r, input int len, input int cut, input bit incr);
    fbase[r][ft[r]] = wp[r];
    flen[r][ft[r]] = len;
    fcut[r][ft[r]] = cut;
    for (int i = 0; i < len; i++) mem[r][wp[r] + i] = incr ? 8'(i + 1) : 8'($urandom);
    wp[r] += len;
    ft[r]++;
  endtask

  task automatic drive();
    for (int r = 0; r < N; r++) begin
      bit on;
      on = pending(r) && !cutw[r];
      s_valid[r] = on;
      s_data[r*8 +: 8] = on ? mem[r][fbase[r][fh[r]] + idx[r]] : 8'h00;
      s_last[r] = on && idx[r] == flen[r][fh[r]] - 1;
    end
  endtask

  task automatic pop(input int r);
    fh[r]++;
    idx[r] = 0;
    cutw[r] = 0;
  endtask

  task automatic update();
    for (int r = 0; r < N; r++) begin
      if (cutw[r]) pop(r);
      else if (hs[r]) begin
        idx[r]++;
        if (idx[r] == flen[r][fh[r]] || idx[r] == MAXL) pop(r);
        else if (idx[r] == fcut[r][fh[r]]) cutw[r] = 1;
      end
    end
    drive();
  endtask

  task automatic start_burst();
    int pick, nd, len, cut, base;
    pick = -1;
    for (int k = N; k >= 1; k--) if (pending((mptr + k) % N)) pick = (mptr + k) % N;
    chk("burst_has_requester", pick >= 0, 1);
    exp_len = 0;
    exp_kind = 3'b000;
    if (pick >= 0) begin
      mptr = pick;
      chk("grant_id", grant_id, pick);
      base = fbase[pick][fh[pick]];
      len = flen[pick][fh[pick]];
      cut = fcut[pick][fh[pick]];
      nd = cut != 0 ? cut : (len > MAXL ? MAXL : len);
      exp_kind = cut != 0 ? 3'b010 : (len > MAXL ? 3'b001 : 3'b100);
      for (int i = 0; i < PRE; i++) expb[i] = 8'h55;
      expb[PRE] = 8'hD5;
      for (int i = 0; i < nd; i++) expb[PRE + 1 + i] = mem[pick][base + i];
      exp_len = PRE + 1 + nd;
    end
    chk("grant_to_en_latency", {busy_d2, busy_d1}, 2'b01);
    chk("ready_in_preamble", s_ready, 0);
    if (have_prev && b2b) begin
      if (prev_kind == 3'b010) chk("gap_min_after_underrun", gap >= IFG + 1, 1);
      else chk("gap", gap, IFG + 1);
    end
    in_burst = 1;
    pos = 0;
  endtask

  task automatic step();
    logic [2:0] pexp;
    @(negedge clk);
    pexp = (!en && in_burst) ? exp_kind : 3'b000;
    if (en && !in_burst) start_burst();
    if (en) begin
      if (pos < exp_len) chk("txd", txd, expb[pos]);
      else chk("burst_too_long", pos, exp_len);
      pos++;
    end else begin
      chk("txd_idle", txd, 0);
      if (in_burst) begin
        chk("burst_len", pos, exp_len);
        chk("ready_after_end", s_ready, 0);
        in_burst = 0;
        prev_kind = exp_kind;
        gap = 1;
        have_prev = 1;
        b2b = tx_enable && (pending(0) || pending(1));
      end else gap++;
    end
    chk("pulses", {frame_done, underrun, oversize}, pexp);
    hs = s_valid & s_ready;
    busy_d2 = busy_d1;
    busy_d1 = busy;
    @(posedge clk);
    #1;
    update();
  endtask

  task automatic run_until_idle(input int limit);
    bit done;
    done = 0;
    for (int i = 0; i < limit && !done; i++) begin
      step();
      done = !pending(0) && !pending(1) && !busy && !in_burst;
    end
    chk("idle_reached", done, 1);
  endtask

  task automatic model_reset();
    for (int r = 0; r < N; r++) begin
      fh[r] = ft[r];
      idx[r] = 0;
      cutw[r] = 0;
    end
    in_burst = 0;
    have_prev = 0;
    mptr = N - 1;
    busy_d1 = 0;
    busy_d2 = 0;
  endtask

  initial begin
    s_valid = '0;
    s_last = '0;
    s_data = '0;
    hs = '0;
    model_reset();
    rst = 1'b0;
    drive();
    #1 rst = 1'b1;
    #1;
    chk("rst_en", en, 0);
    chk("rst_txd", txd, 0);
    chk("rst_ready", s_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_pulses", {frame_done, underrun, oversize}, 0);
    step();
    step();
    rst = 1'b0;
    tx_enable = 1'b1;
    add_frame(0, 64, 0, 1);
    drive();
    run_until_idle(400);
    for (int i = 0; i < 3; i++) begin
      add_frame(0, 10, 0, 0);
      add_frame(1, 10, 0, 0);
    end
    drive();
    run_until_idle(600);
    add_frame(1, 20, 5, 0);
    add_frame(0, 8, 0, 0);
    drive();
    run_until_idle(300);
    add_frame(0, MAXL + 10, 0, 0);
    add_frame(1, MAXL, 0, 0);
    drive();
    run_until_idle(600);
    tx_enable = 1'b0;
    add_frame(0, 12, 0, 0);
    drive();
    for (int i = 0; i < 20; i++) begin
      step();
      chk("busy_while_disabled", busy, 0);
    end
    tx_enable = 1'b1;
    for (int i = 0; i < 15; i++) step();
    tx_enable = 1'b0;
    run_until_idle(300);
    tx_enable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      int r, len, cut;
      r = $urandom_range(0, 1);
      len = $urandom_range(1, 40);
      cut = (len > 2 && $urandom_range(0, 3) == 0) ? $urandom_range(1, len - 1) : 0;
      add_frame(r, len, cut, 0);
    end
    drive();
    run_until_idle(3000);
    add_frame(0, 60, 0, 1);
    drive();
    for (int i = 0; i < 20; i++) step();
    #2 rst = 1'b1;
    #1;
    chk("midrst_en", en, 0);
    chk("midrst_txd", txd, 0);
    chk("midrst_ready", s_ready, 0);
    chk("midrst_busy", busy, 0);
    model_reset();
    add_frame(1, 6, 0, 0);
    add_frame(0, 6, 0, 0);
    drive();
    step();
    step();
    rst = 1'b0;
    run_until_idle(300);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
